main_buffer_ctrl: RTL and testbench

//  Sequencer for the 4x16-byte sliding-row main buffer feeding the window datapath.

---
 rtl/main_buf_pkg.sv | 29 ++
 rtl/main_buffer_ctrl_window_sweep_counter.sv | 31 +++
 rtl/main_buffer_ctrl.sv | 134 +++++++++++++
 tb/tb_main_buffer_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/main_buf_pkg.sv
// Shared constants and state encoding for the main-buffer controller and its 4x16-byte buffer.
// Also holds a saturating-increment helper for the optional statistics counters.
package main_buf_pkg;

  localparam int BUF_ROWS      = 4;
  localparam int BUF_COLS      = 16;
  localparam int WORD_BYTES    = 4;
  localparam int WORDS_PER_ROW = BUF_COLS / WORD_BYTES;

  // Fixed encodings so existing netlists and tools keep seeing the same state values.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_SWEEP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    FILL  = S_FILL,
    SHIFT = S_SHIFT,
    SWEEP = S_SWEEP,
    DONE  = S_DONE
  } ctrl_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/main_buffer_ctrl_window_sweep_counter.sv
// Column pointer for the window sweep: steps by STRIDE on each handshake, holds while stalled,
// and wraps to 0 after the last window position so the next band starts at column 0.
module window_sweep_counter #(
  parameter int STRIDE   = 1,
  parameter int COL_W    = 4,
  parameter int LAST_COL = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [COL_W-1:0] LAST_C = COL_W'(LAST_COL);
  localparam logic [COL_W-1:0] STEP_C = COL_W'(STRIDE);

  assign last = (col == LAST_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
    end else if (clear || (advance && last)) begin
      col <= '0;
    end else if (advance) begin
      col <= col + STEP_C;
    end
  end

endmodule

// File: rtl/main_buffer_ctrl.sv
// Sequencer for the 4x16-byte sliding-row main buffer: fills rows, shifts, sweeps 4x4 windows.
// Optional statistics outputs (win_count, stall_count) are built when MAIN_BUF_CTRL_STATS_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for start; all outputs low
//  FILL  | accepting one image row into buffer row 3, one word per handshake
//  SHIFT | one-cycle shift_up, rows 0..2 <= rows 1..3
//  SWEEP | presenting windows at read_index = col, advancing on win handshake
//  DONE  | one-cycle frame_done pulse
module main_buffer_ctrl
  import main_buf_pkg::*;
#(
  parameter int ROW_BYTES  = main_buf_pkg::BUF_COLS,
  parameter int WORD_BYTES = main_buf_pkg::WORD_BYTES,
  parameter int WIN        = main_buf_pkg::BUF_ROWS,
  parameter int STRIDE     = 1,
  parameter int ROWS_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROWS_W-1:0] num_rows,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              write_en,
  output logic [3:0]        write_index,
  output logic              shift_up,
  output logic [3:0]        read_index,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              frame_done
`ifdef MAIN_BUF_CTRL_STATS_EN
  ,
  output logic [15:0]       win_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int WPR  = ROW_BYTES / WORD_BYTES;
  localparam int WC_W = (WPR > 1) ? $clog2(WPR) : 1;
  localparam logic [WC_W-1:0]   WC_LAST = WC_W'(WPR - 1);
  localparam logic [ROWS_W:0]   WIN_C   = (ROWS_W + 1)'(WIN);

  ctrl_state_t       state, state_nxt;
  logic [WC_W-1:0]   word_cnt;
  logic [ROWS_W-1:0] row_cnt;
  logic [ROWS_W-1:0] rows_q;
  logic [3:0]        col;
  logic              col_last;
  logic              frame_start;
  logic              accept;
  logic              row_done;
  logic              win_hs;
  logic              rows_left;
  logic              priming;

  assign frame_start = (state == IDLE) && start;
  assign accept      = in_valid && in_ready;
  assign row_done    = accept && (word_cnt == WC_LAST);
  assign win_hs      = win_valid && win_ready;
  assign rows_left   = (row_cnt < rows_q);
  // Evaluated before row_cnt increments: true while the row just finished is one of the first WIN-1.
  assign priming     = (({1'b0, row_cnt} + 1'b1) < WIN_C);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_rows == '0) ? DONE : FILL;
      FILL:    if (row_done) state_nxt = priming ? SHIFT : SWEEP;
      SHIFT:   state_nxt = rows_left ? FILL : DONE;
      SWEEP:   if (win_hs && col_last) state_nxt = rows_left ? SHIFT : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      row_cnt  <= '0;
      rows_q   <= '0;
    end else begin
      state <= state_nxt;
      if (frame_start) begin
        rows_q   <= num_rows;
        word_cnt <= '0;
        row_cnt  <= '0;
      end else if (accept) begin
        word_cnt <= row_done ? '0 : word_cnt + 1'b1;
        if (row_done) row_cnt <= row_cnt + 1'b1;
      end
    end
  end

  window_sweep_counter #(
    .STRIDE   (STRIDE),
    .COL_W    (4),
    .LAST_COL (ROW_BYTES - WIN)
  ) u_sweep (
    .clk     (clk),
    .rst     (rst),
    .clear   (frame_start),
    .advance (win_hs),
    .col     (col),
    .last    (col_last)
  );

  assign in_ready    = (state == FILL);
  assign write_en    = accept;
  assign write_index = 4'(int'(word_cnt) * WORD_BYTES);
  assign shift_up    = (state == SHIFT);
  assign win_valid   = (state == SWEEP);
  assign read_index  = col;
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);

`ifdef MAIN_BUF_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_count   <= '0;
      stall_count <= '0;
    end else if (frame_start) begin
      win_count   <= '0;
      stall_count <= '0;
    end else begin
      if (win_hs) win_count <= sat_inc16(win_count);
      if (win_valid && !win_ready) stall_count <= sat_inc16(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_main_buffer_ctrl.sv
// Self-checking bench for main_buffer_ctrl: a byte-level model of the 4x16 buffer plus the image
// decides every expected write index, window position, window contents and event count.
module tb_main_buffer_ctrl;

  localparam int STRIDE = 1;
  localparam int WPB    = (16 - 4) / STRIDE + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_rows = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       write_en;
  logic [3:0] write_index;
  logic       shift_up;
  logic [3:0] read_index;
  logic       win_valid;
  logic       win_ready = 1'b0;
  logic       busy;
  logic       frame_done;
`ifdef MAIN_BUF_CTRL_STATS_EN
  logic [15:0] win_count;
  logic [15:0] stall_count;
`endif

  int n_err = 0;
  int n_checks = 0;

  logic [7:0] img [8][16];
  logic [7:0] bm  [4][16];

  main_buffer_ctrl #(
    .ROW_BYTES(16), .WORD_BYTES(4), .WIN(4), .STRIDE(STRIDE), .ROWS_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .write_en(write_en),
    .write_index(write_index), .shift_up(shift_up), .read_index(read_index),
    .win_valid(win_valid), .win_ready(win_ready), .busy(busy),
    .frame_done(frame_done)
`ifdef MAIN_BUF_CTRL_STATS_EN
    , .win_count(win_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"},    in_ready,    0);
    chk({tag, "_write_en"},    write_en,    0);
    chk({tag, "_shift_up"},    shift_up,    0);
    chk({tag, "_read_index"},  read_index,  0);
    chk({tag, "_win_valid"},   win_valid,   0);
    chk({tag, "_busy"},        busy,        0);
    chk({tag, "_frame_done"},  frame_done,  0);
    chk({tag, "_write_index"}, write_index, 0);
  endtask

  // Runs one frame; abort_at>0 returns mid-sweep after that many windows (caller resets the DUT).
  task automatic run_frame(input int nr, input int vmode, input int rmode, input int abort_at);
    int w, wins, shifts, stalls, cyc, band, ec;
    bit prev_stall, ok, seen_done;
    logic [3:0] prev_ri;
    int exp_wins, exp_shifts;
    w = 0; wins = 0; shifts = 0; stalls = 0; prev_stall = 0; prev_ri = '0; seen_done = 0;
    exp_wins   = (nr < 4) ? 0 : (nr - 3) * WPB;
    exp_shifts = (nr < 4) ? nr : 3 + (nr - 4);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);

    @(negedge clk);
    start = 1'b1; num_rows = 8'(nr); in_valid = 1'b0; win_ready = 1'b0;
    #1;
    chk("pre_start_busy", busy, 0);
    for (cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 6 && nr >= 2) begin
        start = 1'b1;
        num_rows = 8'd1;
      end
      case (vmode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 3 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      case (rmode)
        0: win_ready = 1'b1;
        1: win_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      chk("write_en_is_handshake", write_en, in_valid & in_ready);
      chk("busy_in_frame", busy, 1);
      if (in_ready) chk("fill_exclusive", shift_up | win_valid, 0);
      if (prev_stall) begin
        chk("stall_hold_valid", win_valid, 1);
        chk("stall_hold_index", read_index, prev_ri);
      end
      if (win_valid && win_ready) begin
        band = wins / WPB;
        ec   = (wins % WPB) * STRIDE;
        chk("win_read_index", read_index, ec);
        ok = 1;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (int'(read_index) + c > 15 || band + r > 7 ||
                bm[r][int'(read_index) + c] !== img[band + r][ec + c]) ok = 0;
        chk("win_data", ok, 1);
        wins++;
      end
      if (win_valid && !win_ready) stalls++;
      prev_stall = win_valid && !win_ready;
      prev_ri    = read_index;
      if (write_en) begin
        chk("write_index", write_index, (w % 4) * 4);
        for (int k = 0; k < 4; k++)
          if (int'(write_index) + k < 16 && w / 4 < 8)
            bm[3][int'(write_index) + k] = img[w / 4][(w % 4) * 4 + k];
        w++;
      end
      if (shift_up) begin
        chk("shift_without_write", write_en, 0);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 16; c++) bm[r][c] = bm[r + 1][c];
        shifts++;
      end
      if (abort_at > 0 && wins == abort_at) return;
      if (frame_done) begin
        seen_done = 1;
        break;
      end
    end
    chk("frame_done_seen", seen_done, 1);
    chk("total_writes", w, nr * 4);
    chk("total_shifts", shifts, exp_shifts);
    chk("total_windows", wins, exp_wins);
    if (nr == 0) chk("empty_frame_done_cycle", cyc, 1);
`ifdef MAIN_BUF_CTRL_STATS_EN
    chk("stats_win_count", win_count, wins);
    chk("stats_stall_count", stall_count, stalls);
`endif
    @(negedge clk);
    #1;
    chk("post_frame_busy", busy, 0);
    chk("post_frame_done_pulse", frame_done, 0);
    chk("post_frame_write_en", write_en, 0);
    num_rows = 8'd0;
  endtask

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++) bm[r][c] = 8'd0;
    rst = 1'b1;
    in_valid = 1'b1;
    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    run_frame(4, 0, 0, 0);
    run_frame(6, 0, 0, 0);
    run_frame(5, 0, 1, 0);
    run_frame(4, 1, 0, 0);
    run_frame(2, 0, 0, 0);
    run_frame(0, 0, 0, 0);
    run_frame(6, 2, 2, 0);
    run_frame(3, 2, 2, 0);

    run_frame(4, 0, 0, 5);
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_sweep_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("no_done_in_reset", frame_done, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    win_ready = 1'b0;
    #1;
    chk("after_reset_idle", busy, 0);
    run_frame(4, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
